// File: rtl/rr_grant_ctrl_pkg.sv
// Shared types and helpers for the round-robin grant controller.
package rr_arb_pkg;

   typedef enum logic {IDLE, BUSY} rr_state_t;

   // Index of the lowest set bit of a one-hot vector (0 when empty).
   function automatic logic [31:0] onehot_to_idx(input logic [63:0] vec);
      logic [31:0] idx;
      idx = '0;
      for (int i = 63; i >= 0; i--) begin
         if (vec[i]) idx = 32'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: first set bit of vec at or above base, else first set bit overall.
module rr_pick #(
   parameter int N_REQ = 4,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] vec,
   input  logic [IDX_W-1:0] base,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   logic             m_found;
   logic [IDX_W-1:0] m_idx;
   logic             u_found;
   logic [IDX_W-1:0] u_idx;

   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      m_found = 1'b0;
      m_idx   = '0;
      u_found = 1'b0;
      u_idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (vec[i] && (i >= int'(base)) && !m_found) begin
            m_found = 1'b1;
            m_idx   = IDX_W'(i);
         end
         if (vec[i] && !u_found) begin
            u_found = 1'b1;
            u_idx   = IDX_W'(i);
         end
      end
      found = u_found;
      idx   = m_found ? m_idx : u_idx;
   end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller with grant locking and hold-limit preemption.
module rr_grant_ctrl
   import rr_arb_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int MAX_HOLD = 8,
   localparam int IDX_W   = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             preempt
);

   localparam int HC_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

   rr_state_t        state, state_n;
   logic [IDX_W-1:0] ptr, ptr_n;
   logic [HC_W-1:0]  hold_cnt, hold_n;
   logic [N_REQ-1:0] gnt_n;
   logic [IDX_W-1:0] gnt_idx_n;
   logic             preempt_n;

   logic [N_REQ-1:0] pick_vec;
   logic [IDX_W-1:0] pick_base;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_found;
   logic [IDX_W-1:0] nxt;
   logic [N_REQ-1:0] others;
   logic             timeout;

   // Wrap explicitly so ptr never reaches N_REQ when N_REQ is not a power of two.
   assign nxt     = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : IDX_W'(gnt_idx + 1'b1);
   assign others  = req & ~gnt;
   assign timeout = (MAX_HOLD != 0) && (hold_cnt == HC_W'(MAX_HOLD)) && req[gnt_idx] && (|others);

   // Idle searches all requests from ptr; busy always excludes the current winner.
   assign pick_vec  = (state == IDLE) ? req : others;
   assign pick_base = (state == IDLE) ? ptr : nxt;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .vec   (pick_vec),
      .base  (pick_base),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= '0;
         hold_cnt <= '0;
         gnt      <= '0;
         gnt_idx  <= '0;
         preempt  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         state    <= state_n;
         ptr      <= ptr_n;
         hold_cnt <= hold_n;
         gnt      <= gnt_n;
         gnt_idx  <= gnt_idx_n;
         preempt  <= preempt_n;
      end
   end

   always_comb begin
      state_n   = state;
      ptr_n     = ptr;
      hold_n    = hold_cnt;
      gnt_n     = gnt;
      gnt_idx_n = gnt_idx;
      preempt_n = 1'b0;
      unique case (state)
         IDLE: begin
            if (pick_found) begin
               state_n   = BUSY;
               gnt_n     = ONE << pick_idx;
               gnt_idx_n = pick_idx;
               hold_n    = HC_W'(1);
            end
         end
         BUSY: begin
            if (!req[gnt_idx]) begin
               ptr_n = nxt;
               if (pick_found) begin
                  gnt_n     = ONE << pick_idx;
                  gnt_idx_n = pick_idx;
                  hold_n    = HC_W'(1);
               end else begin
                  state_n   = IDLE;
                  gnt_n     = '0;
                  gnt_idx_n = '0;
                  hold_n    = '0;
               end
            end else if (timeout) begin
               ptr_n     = nxt;
               gnt_n     = ONE << pick_idx;
               gnt_idx_n = pick_idx;
               hold_n    = HC_W'(1);
               preempt_n = 1'b1;
            end else if (hold_cnt < HC_W'(MAX_HOLD)) begin
               hold_n = hold_cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      gnt_valid = |gnt;
   end

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed plus randomized bench for rr_grant_ctrl against an owner/pointer reference model.
module tb_rr_grant_ctrl;

   localparam int N  = 4;
   localparam int MH = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req;
   logic [N-1:0] gnt;
   logic [1:0]   gnt_idx;
   logic         gnt_valid;
   logic         preempt;

   int compared   = 0;
   int mismatched = 0;

   // Reference model: owner is the granted requester, -1 when idle.
   int owner = -1;
   int mptr  = 0;
   int mhold = 0;
   bit mpre  = 1'b0;

   int wait_cnt [N];
   int max_wait;
   int pre_seen;

   rr_grant_ctrl #(.N_REQ(N), .MAX_HOLD(MH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .preempt   (preempt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      assert (act === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input int base);
      for (int k = 0; k < N; k++) begin
         if (v[(base + k) % N]) return (base + k) % N;
      end
      return -1;
   endfunction

   function automatic void model_reset();
      owner = -1; mptr = 0; mhold = 0; mpre = 1'b0;
   endfunction

   function automatic void model_step(input logic [N-1:0] r);
      logic [N-1:0] oth;
      int p;
      mpre = 1'b0;
      if (owner < 0) begin
         p = pick(r, mptr);
         if (p >= 0) begin owner = p; mhold = 1; end
      end else if (!r[owner]) begin
         mptr = (owner + 1) % N;
         p = pick(r, mptr);
         if (p >= 0) begin owner = p; mhold = 1; end
         else begin owner = -1; mhold = 0; end
      end else begin
         oth = r;
         oth[owner] = 1'b0;
         if (MH != 0 && mhold == MH && oth != 0) begin
            mptr  = (owner + 1) % N;
            owner = pick(oth, mptr);
            mhold = 1;
            mpre  = 1'b1;
         end else if (mhold < MH) begin
            mhold++;
         end
      end
   endfunction

   task automatic check_outputs(input string tag);
      logic [N-1:0] eg;
      eg = (owner < 0) ? '0 : N'(1 << owner);
      check({tag, ".gnt"},     32'(gnt),       32'(eg));
      check({tag, ".idx"},     32'(gnt_idx),   (owner < 0) ? 32'd0 : 32'(owner));
      check({tag, ".valid"},   32'(gnt_valid), 32'(owner >= 0));
      check({tag, ".preempt"}, 32'(preempt),   32'(mpre));
   endtask

   // One clock: drive at negedge, update model at posedge, sample 1 ns later.
   task automatic cycle(input logic [N-1:0] r, input string tag);
      @(negedge clk);
      req = r;
      @(posedge clk);
      if (rst) model_reset(); else model_step(r);
      #1;
      check_outputs(tag);
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      model_reset();
      #12;
      check_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) cycle(4'b0000, "idle");

      cycle(4'b1010, "first_grant");
      check("first_gnt_const", 32'(gnt), 32'h2);
      cycle(4'b1000, "no_bubble");
      check("no_bubble_const", 32'(gnt), 32'h8);
      cycle(4'b0000, "back_idle");

      // All requesting: rotation with preemption every MH cycles.
      foreach (wait_cnt[i]) wait_cnt[i] = 0;
      max_wait = 0;
      pre_seen = 0;
      for (int c = 0; c < 40; c++) begin
         cycle(4'b1111, "rotate");
         if (preempt) pre_seen++;
         for (int i = 0; i < N; i++) begin
            if (gnt[i]) wait_cnt[i] = 0;
            else wait_cnt[i]++;
            if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
         end
      end
      check("fair_max_wait_le_16", 32'(max_wait <= N * MH), 32'd1);
      check("rotate_preempts", 32'(pre_seen), 32'd9);
      cycle(4'b0000, "rotate_end");

      // Lone requester is never preempted, then loses immediately once another arrives.
      pre_seen = 0;
      for (int c = 0; c < 20; c++) begin
         cycle(4'b0100, "alone");
         if (preempt) pre_seen++;
      end
      check("alone_no_preempt", 32'(pre_seen), 32'd0);
      cycle(4'b0101, "forced_switch");
      check("forced_gnt_const", 32'(gnt), 32'h1);
      check("forced_pre_const", 32'(preempt), 32'd1);
      cycle(4'b0001, "preempt_drop");
      check("preempt_one_cycle", 32'(preempt), 32'd0);
      cycle(4'b0000, "idle2");

      // Wrap: release of requester 3 moves ptr to 0, so 0 beats 1.
      cycle(4'b1000, "wrap_grant3");
      cycle(4'b1011, "wrap_hold");
      cycle(4'b0011, "wrap_release");
      check("wrap_const", 32'(gnt), 32'h1);
      cycle(4'b0000, "idle3");

      // Asynchronous reset while requester 1 holds the grant.
      cycle(4'b0010, "pre_rst");
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs("async_rst");
      cycle(4'b0000, "in_rst");
      @(negedge clk);
      rst = 1'b0;
      cycle(4'b0110, "post_rst");
      check("post_rst_const", 32'(gnt), 32'h2);
      cycle(4'b0000, "idle4");

      // Random traffic: each request bit toggles with low probability to get long holds.
      req = '0;
      for (int c = 0; c < 400; c++) begin
         logic [N-1:0] r;
         r = req;
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
         end
         cycle(r, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
